// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcode, flag and writeback entry definitions
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_XOR = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_NOR = 3'b100;
  localparam logic [2:0] OP_SL  = 3'b101;
  localparam logic [2:0] OP_SR  = 3'b110;

  // Bit positions inside the {N,Z,C,V} status register.
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // Width-independent part of a buffered entry. Result and destination
  // index are parameterised by the stage and are packed around this.
  typedef struct packed {
    logic       cout;
    logic       z;
    logic       n;
    logic       o;
    logic [2:0] opcode;
    logic       flag_we;
  } wb_entry_t;

  localparam int ENTRY_SIDE_W = $bits(wb_entry_t);

endpackage

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - in-order synchronous FIFO for the writeback stage
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   push, wdata       write one word (ignored when full)
//   pop               drop the head word (ignored when empty)
//   rdata             head word, 0 while empty
//   occupancy         words held, 0..DEPTH
//   full, empty       occupancy == DEPTH / occupancy == 0
module wb_fifo #(
  parameter int W     = 40,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [W-1:0]             wdata,
  input  logic                     pop,
  output logic [W-1:0]             rdata,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   count;

  logic do_push;
  logic do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign occupancy = count;
  assign rdata     = empty ? '0 : mem[rptr];

  // Storage is not reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

  // DEPTH is a power of two, so natural pointer overflow wraps modulo DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/alu_wb_stage.sv
// rtl/alu_wb_stage.sv - ALU writeback stage with status flags and sticky overflow
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   in_valid/in_ready               ALU entry handshake
//   in_result, in_cout, in_z, in_n,
//   in_o, in_opcode, in_rd,
//   in_flag_we                      entry payload
//   wb_valid/wb_ready               register-file write handshake
//   wb_data, wb_rd                  head entry result and destination
//   flags                           {N,Z,C,V} of retired entries
//   ovf_sticky, clr_sticky          sticky ADD overflow and its clear
//   occupancy                       entries buffered
module alu_wb_stage
  import alu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 3,
  parameter int DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_W-1:0]      in_result,
  input  logic                   in_cout,
  input  logic                   in_z,
  input  logic                   in_n,
  input  logic                   in_o,
  input  logic [2:0]             in_opcode,
  input  logic [REG_AW-1:0]      in_rd,
  input  logic                   in_flag_we,
  output logic                   wb_valid,
  input  logic                   wb_ready,
  output logic [DATA_W-1:0]      wb_data,
  output logic [REG_AW-1:0]      wb_rd,
  output logic [3:0]             flags,
  output logic                   ovf_sticky,
  input  logic                   clr_sticky,
  output logic [$clog2(DEPTH):0] occupancy
);

  localparam int ENTRY_W = DATA_W + REG_AW + ENTRY_SIDE_W;

  wb_entry_t            in_side;
  wb_entry_t            head_side;
  logic [ENTRY_W-1:0]   wdata;
  logic [ENTRY_W-1:0]   rdata;
  logic                 full;
  logic                 empty;
  logic                 push;
  logic                 pop;
  logic [3:0]           flags_q;
  logic                 sticky_q;
  logic                 head_is_add;

  assign in_side.cout    = in_cout;
  assign in_side.z       = in_z;
  assign in_side.n       = in_n;
  assign in_side.o       = in_o;
  assign in_side.opcode  = in_opcode;
  assign in_side.flag_we = in_flag_we;

  assign wdata = {in_result, in_rd, in_side};
  assign {wb_data, wb_rd, head_side} = rdata;

  // Ready depends only on stored state: a full stage never accepts, even
  // if the head is leaving in the same cycle.
  assign in_ready = !full;
  assign wb_valid = !empty;
  assign push     = in_valid && in_ready;
  assign pop      = wb_valid && wb_ready;

  wb_fifo #(
    .W     (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .wdata     (wdata),
    .pop       (pop),
    .rdata     (rdata),
    .occupancy (occupancy),
    .full      (full),
    .empty     (empty)
  );

  assign head_is_add = (head_side.opcode == OP_ADD);

  // Flags track retired entries only; carry and overflow are meaningful
  // just for ADD, so other opcodes leave C and V alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= 4'b0000;
    end else if (pop && head_side.flag_we) begin
      flags_q[FLAG_N] <= head_side.n;
      flags_q[FLAG_Z] <= head_side.z;
      if (head_is_add) begin
        flags_q[FLAG_C] <= head_side.cout;
        flags_q[FLAG_V] <= head_side.o;
      end
    end
  end

  // Set has priority over clear so an overflow retiring alongside a
  // clear request is never lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_q <= 1'b0;
    end else if (pop && head_side.flag_we && head_is_add && head_side.o) begin
      sticky_q <= 1'b1;
    end else if (clr_sticky) begin
      sticky_q <= 1'b0;
    end
  end

  assign flags      = flags_q;
  assign ovf_sticky = sticky_q;

endmodule
